// File: rtl/cic_channel_scheduler_if.sv
// Output sample stream of the CIC channel scheduler: the FIFO head sample,
// its channel tag and last-channel flag, with a valid/ready handshake.
interface cic_channel_scheduler_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int CHANNELS_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]     m_data;
  logic [CHANNELS_WIDTH-1:0] m_chan;
  logic                      m_last;
  logic                      m_valid;
  logic                      m_ready;

  modport master (output m_data, output m_chan, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_chan, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/cic_channel_scheduler.sv
// CIC channel scheduler: sweeps the shared integrator/comb datapath over all
// microphone channels once per PDM frame (two cycles per channel), captures
// comb outputs on decimation frames into an output FIFO and streams them out.
// Optional feature: define CIC_SCHED_DROP_COUNT_EN to add the saturating
// drop_count output.
module cic_channel_scheduler #(
  parameter int CHANNELS       = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int CHANNELS_WIDTH = $clog2(CHANNELS),
  parameter int LEVEL_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_start,
  input  logic                      comb_enable,
  input  logic [DATA_WIDTH-1:0]     comb_data,
  output logic [CHANNELS_WIDTH-1:0] channel,
  output logic                      phase,
  output logic                      busy,
  output logic                      frame_done,
  cic_channel_scheduler_if.master   m,
  output logic [LEVEL_WIDTH-1:0]    fifo_level,
  output logic                      overflow,
  output logic                      sync_err,
  input  logic                      err_clr
`ifdef CIC_SCHED_DROP_COUNT_EN
  ,
  output logic [7:0]                drop_count
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = CHANNELS_WIDTH + 1 + DATA_WIDTH;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                    state_r, state_s;
  logic [CHANNELS_WIDTH-1:0] chan_r, chan_s;
  logic                      phase_r, phase_s;
  logic                      comb_frame_r, comb_frame_s;
  logic                      frame_done_r, done_s;
  logic                      last_chan_s;
  logic                      busy_s, push_s, sync_hit_s;

  logic [ENTRY_W-1:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_r, rd_r, rd_nxt_s;
  logic [LEVEL_WIDTH-1:0]    level_r, level_nxt_s;
  logic                      valid_r;
  logic [ENTRY_W-1:0]        head_r, head_s, entry_s;
  logic                      full_s, pop_s, accept_s, drop_s;
  logic                      overflow_r, sync_err_r;

  assign last_chan_s = (chan_r == CHANNELS_WIDTH'(CHANNELS - 1));

  // Sweep state register: state, channel, phase, latched comb flag, done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      chan_r       <= {CHANNELS_WIDTH{1'b0}};
      phase_r      <= 1'b0;
      comb_frame_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      chan_r       <= chan_s;
      phase_r      <= phase_s;
      comb_frame_r <= comb_frame_s;
      frame_done_r <= done_s;
    end
  end

  // Next-state logic: two cycles per channel, back to IDLE after the last one.
  always_comb begin
    state_s      = state_r;
    chan_s       = chan_r;
    phase_s      = phase_r;
    comb_frame_s = comb_frame_r;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        chan_s  = {CHANNELS_WIDTH{1'b0}};
        phase_s = 1'b0;
        if (frame_start) begin
          state_s      = ST_RUN;
          comb_frame_s = comb_enable;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        phase_s = ~phase_r;
        if (phase_r) begin
          if (last_chan_s) begin
            chan_s  = {CHANNELS_WIDTH{1'b0}};
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            chan_s = chan_r + CHANNELS_WIDTH'(1);
          end
        end else begin
          chan_s = chan_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        chan_s  = {CHANNELS_WIDTH{1'b0}};
        phase_s = 1'b0;
      end
    endcase
  end

  // Sweep-derived controls: busy, capture request, and overlapping-frame detect.
  always_comb begin
    busy_s     = 1'b0;
    push_s     = 1'b0;
    sync_hit_s = 1'b0;
    if (state_r == ST_RUN) begin
      busy_s     = 1'b1;
      push_s     = phase_r & comb_frame_r;
      sync_hit_s = frame_start;
    end else begin
      busy_s     = 1'b0;
      push_s     = 1'b0;
      sync_hit_s = 1'b0;
    end
  end

  assign full_s      = (level_r == LEVEL_WIDTH'(FIFO_DEPTH));
  assign pop_s       = valid_r & m.m_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept_s    = push_s & (~full_s | pop_s);
  assign drop_s      = push_s & full_s & ~pop_s;
  assign entry_s     = {chan_r, last_chan_s, comb_data};
  assign rd_nxt_s    = pop_s ? (rd_r + PTR_W'(1)) : rd_r;
  assign level_nxt_s = level_r + LEVEL_WIDTH'(accept_s) - LEVEL_WIDTH'(pop_s);

  // Next head: the sample landing in the head slot bypasses the memory.
  always_comb begin
    head_s = mem_r[rd_nxt_s];
    if (accept_s && (wr_r == rd_nxt_s)) begin
      head_s = entry_s;
    end else begin
      head_s = mem_r[rd_nxt_s];
    end
  end

  // FIFO storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_r] <= entry_s;
    end
  end

  // FIFO pointers, level, registered head and sticky error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_r       <= {PTR_W{1'b0}};
      rd_r       <= {PTR_W{1'b0}};
      level_r    <= {LEVEL_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      head_r     <= {ENTRY_W{1'b0}};
      overflow_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_r <= wr_r + PTR_W'(1);
      end
      rd_r       <= rd_nxt_s;
      level_r    <= level_nxt_s;
      valid_r    <= (level_nxt_s != {LEVEL_WIDTH{1'b0}});
      head_r     <= head_s;
      overflow_r <= drop_s | (overflow_r & ~err_clr);
      sync_err_r <= sync_hit_s | (sync_err_r & ~err_clr);
    end
  end

`ifdef CIC_SCHED_DROP_COUNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating dropped-sample counter; a drop in the clearing cycle counts as one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt_r <= 8'd0;
    end else if (err_clr) begin
      drop_cnt_r <= drop_s ? 8'd1 : 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign drop_count = drop_cnt_r;
`endif

  assign channel    = chan_r;
  assign phase      = phase_r;
  assign busy       = busy_s;
  assign frame_done = frame_done_r;
  assign m.m_data   = head_r[DATA_WIDTH-1:0];
  assign m.m_last   = head_r[DATA_WIDTH];
  assign m.m_chan   = head_r[ENTRY_W-1 -: CHANNELS_WIDTH];
  assign m.m_valid  = valid_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;
  assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_cic_channel_scheduler.sv
// Self-checking bench for cic_channel_scheduler: directed scenarios plus a
// randomized run, all checked against a frame/queue level reference model.
module tb_cic_channel_scheduler;
  localparam int CH = 8;
  localparam int CW = 3;
  localparam int DW = 16;
  localparam int FD = 16;
  localparam int LW = 5;

  logic          clk;
  logic          resetn;
  logic          frame_start;
  logic          comb_enable;
  logic [DW-1:0] comb_data;
  logic [CW-1:0] channel;
  logic          phase;
  logic          busy;
  logic          frame_done;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          sync_err;
  logic          err_clr;
`ifdef CIC_SCHED_DROP_COUNT_EN
  logic [7:0]    drop_count;
`endif

  cic_channel_scheduler_if #(.DATA_WIDTH(DW), .CHANNELS_WIDTH(CW)) sif ();

  cic_channel_scheduler #(.CHANNELS(CH), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start), .comb_enable(comb_enable),
    .comb_data(comb_data), .channel(channel), .phase(phase), .busy(busy),
    .frame_done(frame_done), .m(sif), .fifo_level(fifo_level), .overflow(overflow),
    .sync_err(sync_err), .err_clr(err_clr)
`ifdef CIC_SCHED_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  // Per-channel sample table; the datapath presents the entry of the owned channel.
  logic [DW-1:0] tbl [CH];
  assign comb_data = tbl[channel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a frame started in cycle fs occupies cycles fs+1..fs+2*CH,
  // channel k in cycles fs+1+2k (integrate) and fs+2+2k (store); done at fs+2*CH+1.
  int            cyc;
  int            fs;
  int            done_cyc;
  bit            fcomb;
  logic [19:0]   mq[$];
  bit            m_ovf;
  bit            m_serr;
  int            m_drops;

  function automatic bit in_sweep(int n);
    return (fs >= 0) && (n > fs) && (n <= fs + 2 * CH);
  endfunction

  // {busy, channel, phase, frame_done} expected in the current cycle.
  function automatic logic [5:0] exp_ctrl();
    int r;
    logic d;
    d = (cyc == done_cyc);
    if (in_sweep(cyc)) begin
      r = cyc - fs - 1;
      return {1'b1, CW'(r / 2), 1'(r % 2), d};
    end
    return {1'b0, 3'd0, 1'b0, d};
  endfunction

  task automatic model_reset();
    fs = -1; done_cyc = -1; fcomb = 1'b0; mq.delete();
    m_ovf = 1'b0; m_serr = 1'b0; m_drops = 0;
  endtask

  // Advance model and DUT by one clock with the currently driven inputs.
  task automatic step();
    int  r;
    int  k;
    bit  pop;
    bit  push;
    bit  drop;
    logic [19:0] e;
    pop  = (mq.size() != 0) && sif.m_ready;
    push = 1'b0;
    e    = 20'd0;
    if (in_sweep(cyc)) begin
      r = cyc - fs - 1;
      k = r / 2;
      if ((r % 2 == 1) && fcomb) begin
        push = 1'b1;
        e = {CW'(k), (k == CH - 1), tbl[k]};
      end
    end
    drop = push && (mq.size() == FD) && !pop;
    if (err_clr) begin m_ovf = 1'b0; m_serr = 1'b0; m_drops = 0; end
    if (drop) begin m_ovf = 1'b1; m_drops = (m_drops < 255) ? m_drops + 1 : 255; end
    if (frame_start) begin
      if (in_sweep(cyc)) m_serr = 1'b1;
      else begin fs = cyc; fcomb = comb_enable; done_cyc = cyc + 2 * CH + 1; end
    end
    if (pop) void'(mq.pop_front());
    if (push && !drop) mq.push_back(e);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic pulse_frame(input bit ce);
    comb_enable = ce; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({channel, phase, busy, frame_done, sif.m_valid, sif.m_data, sif.m_chan, sif.m_last,
         fifo_level, overflow, sync_err} !== 36'd0)
      $display("FAIL reset_outputs got ch=%0d ph=%0b busy=%0b done=%0b v=%0b d=%h lvl=%0d ovf=%0b se=%0b required all 0",
               channel, phase, busy, frame_done, sif.m_valid, sif.m_data, fifo_level, overflow, sync_err);
    else n_pass++;
`ifdef CIC_SCHED_DROP_COUNT_EN
    n_checks++;
    if (drop_count !== 8'd0) $display("FAIL reset_drop_count got %0d required 0", drop_count);
    else n_pass++;
`endif
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_plain_frame();
    int start;
    int done_at;
    done_at = -1;
    pulse_frame(1'b0);
    start = cyc - 1;
    for (int i = 0; i < 22; i++) begin
      n_checks++;
      if ({busy, channel, phase, frame_done} !== exp_ctrl())
        $display("FAIL plain_ctrl cyc=%0d got %h required %h", cyc - start, {busy, channel, phase, frame_done}, exp_ctrl());
      else n_pass++;
      if (frame_done && done_at < 0) done_at = cyc - start;
      step();
    end
    n_checks++;
    if (done_at != 17) $display("FAIL plain_done_latency got %0d required 17", done_at);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 5'd0) $display("FAIL plain_level got %0d required 0", fifo_level);
    else n_pass++;
  endtask

  task automatic test_capture();
    int npop;
    npop = 0;
    for (int k = 0; k < CH; k++) tbl[k] = 16'h1000 + 16'(k);
    sif.m_ready = 1'b1;
    pulse_frame(1'b1);
    for (int i = 0; i < 24; i++) begin
      n_checks++;
      if (sif.m_valid !== (mq.size() != 0))
        $display("FAIL capture_valid got %0b required %0b", sif.m_valid, (mq.size() != 0));
      else n_pass++;
      if (sif.m_valid && mq.size() != 0) begin
        n_checks++;
        if ({sif.m_chan, sif.m_last, sif.m_data} !== mq[0])
          $display("FAIL capture_data got %h required %h", {sif.m_chan, sif.m_last, sif.m_data}, mq[0]);
        else n_pass++;
        npop++;
      end
      step();
    end
    n_checks++;
    if (npop != 8) $display("FAIL capture_count got %0d required 8", npop);
    else n_pass++;
  endtask

  task automatic test_overflow();
    sif.m_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < CH; k++) tbl[k] = 16'(16'h1000 * (f + 1)) + 16'(k);
      pulse_frame(1'b1);
      repeat (16) step();
      if (f == 1) begin
        n_checks++;
        if ({fifo_level, overflow} !== {5'd16, 1'b0})
          $display("FAIL fill_two_frames got lvl=%0d ovf=%0b required lvl=16 ovf=0", fifo_level, overflow);
        else n_pass++;
      end
    end
    n_checks++;
    if ({fifo_level, overflow, sif.m_chan, sif.m_data} !== {5'd16, 1'b1, 3'd0, 16'h1000})
      $display("FAIL overflow_drop got lvl=%0d ovf=%0b head=%0d/%h required lvl=16 ovf=1 head=0/1000",
               fifo_level, overflow, sif.m_chan, sif.m_data);
    else n_pass++;
`ifdef CIC_SCHED_DROP_COUNT_EN
    n_checks++;
    if (drop_count !== 8'(m_drops)) $display("FAIL drop_count got %0d required %0d", drop_count, m_drops);
    else n_pass++;
`endif
  endtask

  task automatic test_full_concurrent();
    logic [5:0] e;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    for (int k = 0; k < CH; k++) tbl[k] = 16'h4000 + 16'(k);
    pulse_frame(1'b1);
    for (int i = 0; i < 17; i++) begin
      e = exp_ctrl();
      sif.m_ready = e[5] & e[1];
      n_checks++;
      if ({fifo_level, overflow} !== {5'd16, 1'b0})
        $display("FAIL full_concurrent got lvl=%0d ovf=%0b required lvl=16 ovf=0", fifo_level, overflow);
      else n_pass++;
      if (sif.m_ready) begin
        n_checks++;
        if ({sif.m_chan, sif.m_last, sif.m_data} !== mq[0])
          $display("FAIL full_head got %h required %h", {sif.m_chan, sif.m_last, sif.m_data}, mq[0]);
        else n_pass++;
      end
      step();
    end
    sif.m_ready = 1'b0;
  endtask

  task automatic test_sync_err();
    int start;
    int done_at;
    done_at = -1;
    pulse_frame(1'b0);
    start = cyc - 1;
    repeat (4) step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    while (cyc < start + 22) begin
      n_checks++;
      if ({busy, channel, phase, frame_done} !== exp_ctrl())
        $display("FAIL sync_ctrl cyc=%0d got %h required %h", cyc - start, {busy, channel, phase, frame_done}, exp_ctrl());
      else n_pass++;
      if (frame_done && done_at < 0) done_at = cyc - start;
      step();
    end
    n_checks++;
    if (done_at != 17 || sync_err !== 1'b1)
      $display("FAIL sync_err_set got done=%0d se=%0b required done=17 se=1", done_at, sync_err);
    else n_pass++;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_checks++;
    if (sync_err !== 1'b0) $display("FAIL sync_err_clear got %0b required 0", sync_err);
    else n_pass++;
    pulse_frame(1'b0);
    repeat (3) step();
    frame_start = 1'b1; err_clr = 1'b1; step(); frame_start = 1'b0; err_clr = 1'b0;
    n_checks++;
    if (sync_err !== 1'b1) $display("FAIL sync_set_wins got %0b required 1", sync_err);
    else n_pass++;
    repeat (14) step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 40 && mq.size() > 1; i++) begin
      sif.m_ready = 1'b1;
      step();
    end
    sif.m_ready = 1'b0;
    for (int k = 0; k < CH; k++) tbl[k] = 16'h5000 + 16'(k);
    pulse_frame(1'b1);
    repeat (7) step();
    n_checks++;
    if ({channel, phase, fifo_level} !== {3'd3, 1'b1, 5'd4})
      $display("FAIL pre_reset got ch=%0d ph=%0b lvl=%0d required ch=3 ph=1 lvl=4", channel, phase, fifo_level);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({channel, busy, sif.m_valid, fifo_level} !== 10'd0)
      $display("FAIL reset_mid_sweep got ch=%0d busy=%0b v=%0b lvl=%0d required all 0",
               channel, busy, sif.m_valid, fifo_level);
    else n_pass++;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({busy, frame_done} !== 2'b00)
        $display("FAIL post_reset_idle got busy=%0b done=%0b required 0 0", busy, frame_done);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      frame_start = ($urandom_range(0, 9) == 0);
      comb_enable = ($urandom_range(0, 3) != 0);
      sif.m_ready = (i < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      err_clr     = ($urandom_range(0, 24) == 0);
      if (frame_start && !in_sweep(cyc))
        for (int k = 0; k < CH; k++) tbl[k] = 16'($urandom);
      step();
      n_checks++;
      if ({busy, channel, phase, frame_done} !== exp_ctrl())
        $display("FAIL rand_ctrl i=%0d got %h required %h", i, {busy, channel, phase, frame_done}, exp_ctrl());
      else n_pass++;
      n_checks++;
      if ({sif.m_valid, fifo_level, overflow, sync_err} !== {(mq.size() != 0), LW'(mq.size()), m_ovf, m_serr})
        $display("FAIL rand_status i=%0d got v=%0b lvl=%0d ovf=%0b se=%0b required v=%0b lvl=%0d ovf=%0b se=%0b",
                 i, sif.m_valid, fifo_level, overflow, sync_err, (mq.size() != 0), mq.size(), m_ovf, m_serr);
      else n_pass++;
      if (mq.size() != 0) begin
        n_checks++;
        if ({sif.m_chan, sif.m_last, sif.m_data} !== mq[0])
          $display("FAIL rand_head i=%0d got %h required %h", i, {sif.m_chan, sif.m_last, sif.m_data}, mq[0]);
        else n_pass++;
      end
`ifdef CIC_SCHED_DROP_COUNT_EN
      n_checks++;
      if (drop_count !== 8'(m_drops)) $display("FAIL rand_drop_count got %0d required %0d", drop_count, m_drops);
      else n_pass++;
`endif
    end
    frame_start = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; frame_start = 1'b0; comb_enable = 1'b0; err_clr = 1'b0; sif.m_ready = 1'b0;
    for (int k = 0; k < CH; k++) tbl[k] = 16'd0;
    cyc = 0;
    model_reset();
    test_reset();
    test_plain_frame();
    test_capture();
    test_overflow();
    test_full_concurrent();
    test_sync_err();
    test_reset_mid_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cic_channel_scheduler.md
Name: cic_channel_scheduler

Overview:
- Sequences the shared CIC integrator/comb datapath across all microphone channels in each PDM frame.
- Drives the channel index and compute phase into the shared datapath.
- On decimation frames, captures each channel's comb output into an internal output FIFO.
- Hands samples to the downstream sample buffer over a valid/ready stream, tagged with channel index and last-channel flag.

Parameters:
- CHANNELS, 8, number of microphone channels time-multiplexed on one datapath (power of 2, >=2).
- DATA_WIDTH, 16, width of comb output sample.
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=CHANNELS).
- CHANNELS_WIDTH, $clog2(CHANNELS), channel index width.
- LEVEL_WIDTH, $clog2(FIFO_DEPTH)+1, FIFO level width.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, asynchronous, active-low.
- frame_start  input  1  one-cycle pulse from the PDM sync block at the end of bit reading time; starts a channel sweep.
- comb_enable  input  1  decimation-frame flag from the sync block; sampled at frame_start.
- comb_data  input  DATA_WIDTH  comb output for the current channel, valid in phase 1.
- channel  output  CHANNELS_WIDTH  channel currently owned by the datapath.
- phase  output  1  0 = integrate step, 1 = comb/store step.
- busy  output  1  sweep in progress.
- frame_done  output  1  one-cycle pulse after the last channel completes.
- m_data  output  DATA_WIDTH  FIFO head sample.
- m_chan  output  CHANNELS_WIDTH  channel tag of head.
- m_last  output  1  head is channel CHANNELS-1.
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  downstream accept.
- fifo_level  output  LEVEL_WIDTH  entries held, 0..FIFO_DEPTH.
- overflow  output  1  sticky: sample dropped on full FIFO.
- sync_err  output  1  sticky: frame_start received while busy.
- err_clr  input  1  clears overflow and sync_err (and drop_count when compiled in).

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; all outputs 0; FIFO empty; latched comb flag 0.
- State IDLE:
  - channel=0, phase=0, busy=0.
  - frame_start=1 -> RUN on next edge; comb_enable latched into comb_frame in the same cycle.
- State RUN:
  - busy=1; phase toggles every cycle, starting at 0, so each channel occupies exactly 2 cycles.
  - When phase=1: channel increments, or wraps to 0 if channel==CHANNELS-1, and state returns to IDLE.
  - frame_done pulses in the first IDLE cycle after the sweep.
  - Sweep length is exactly 2*CHANNELS cycles; frame_start to frame_done latency is 2*CHANNELS+1 cycles.
- Capture:
  - In RUN with phase=1 and comb_frame=1, push {channel, channel==CHANNELS-1, comb_data}.
  - Nothing is pushed in non-decimation frames.
- FIFO:
  - Pop when m_valid && m_ready. m_data/m_chan/m_last are registered from the head and stable while m_valid && !m_ready.
  - fifo_level updates the cycle after the push/pop.
  - Full with push and pop in the same cycle: the push is accepted and the level is unchanged.
  - Full with push and no pop: the sample is dropped, overflow sets, and FIFO contents are untouched.
  - Empty with pop attempt: impossible, since m_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_start while RUN: ignored, sync_err sets, and the sweep continues unchanged.
- Error flags: err_clr clears both flags; if a set event occurs in the same cycle, set wins.
- Reset mid-sweep: immediate return to IDLE with the FIFO flushed; no frame_done is issued.

Optional Feature:
- Macro CIC_SCHED_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count [7:0], counting dropped samples and saturating at 255.
  - Cleared by err_clr; if a drop occurs in the same cycle as err_clr, drop_count becomes 1.
- Undefined: port absent; only the overflow flag reports drops.

Test Plan:
- CHANNELS=8; pulse frame_start with comb_enable=0 -> channel steps 0..7, each held 2 cycles; frame_done 17 cycles after frame_start; fifo_level stays 0.
- frame_start with comb_enable=1, comb_data=0x1000+channel, m_ready=1 -> 8 outputs 0x1000..0x1007 with m_chan 0..7; m_last=1 only on 0x1007.
- FIFO_DEPTH=16, m_ready=0, two decimation frames -> fifo_level=16, overflow=0; a third frame -> all 8 samples dropped, overflow=1, head still 0x1000 of the first frame.
- FIFO full with m_ready=1 during a capture -> each push accepted; level stays 16 while the sweep runs; overflow stays 0.
- frame_start re-pulsed 5 cycles into a sweep -> sync_err=1; frame_done still at the original 17-cycle point; err_clr -> sync_err=0.
- resetn low during channel 3 with 4 entries queued -> channel=0, busy=0, m_valid=0, fifo_level=0 immediately; no frame_done after release.
